// File: rtl/hd63701_irq2_ctrl.sv
// hd63701_irq2_ctrl
// Merges up to eight peripheral interrupt sources onto the HD63701 IRQ2
// request and its 4-bit IRQ2V vector select. The lowest-indexed eligible
// source wins. The vector is latched when the request is raised. The request
// is retired when the core fetches that vector, which this block sees by
// snooping the address bus. It is also retired if the latched source stops
// being eligible.
//
// Ports
//   CLK        core CPU clock (one bus cycle per CLK)
//   RST        synchronous active-high reset
//   SRC        interrupt requests, synchronous to CLK
//   AD, RW     core address bus and read(1)/write(0)
//   WDATA      core data out, sampled on writes to the register block
//   RDATA      register read data, combinational from AD/RW
//   RSEL       AD/RW selects a register for reading (steers the core DI mux)
//   IRQ2       registered interrupt request
//   IRQ2V      registered vector select
//   dbg_state  1 while the scheduler FSM is in REQ
//
// Register block (BASE-relative)
//   +0 ENABLE   R/W
//   +1 PENDING  read pending; write-1-to-clear on edge-sensitive bits only
//   +2 STATUS   read {IRQ2, 3'b0, IRQ2V}
//
// Handshake: IRQ2 stays high, with IRQ2V stable, until one of two events.
// The core reads address {11'h7FF, IRQ2V, 1'b0} (the acknowledge), or the
// latched source is no longer eligible. IRQ2 then drops on the following edge.
module hd63701_irq2_ctrl #(
  parameter int          NSRC       = 8,
  parameter logic [7:0]  LEVEL_MASK = 8'h00,
  parameter logic [15:0] BASE       = 16'h0040,
  parameter logic [3:0]  VOFS       = 4'h0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NSRC-1:0] SRC,
  input  logic [15:0]     AD,
  input  logic            RW,
  input  logic [7:0]      WDATA,
  output logic [7:0]      RDATA,
  output logic            RSEL,
  output logic            IRQ2,
  output logic [3:0]      IRQ2V,
  output logic            dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

  localparam logic [15:0]     A_EN   = BASE;
  localparam logic [15:0]     A_PEND = BASE + 16'd1;
  localparam logic [15:0]     A_STAT = BASE + 16'd2;
  localparam logic [NSRC-1:0] LVL    = LEVEL_MASK[NSRC-1:0];

  state_t          state_q, state_nxt;
  logic [NSRC-1:0] enable_q;
  logic [NSRC-1:0] pending_q, pending_nxt;
  logic [NSRC-1:0] src_d_q;
  logic [3:0]      irq2v_q, irq2v_nxt;
  logic [2:0]      idx_q, idx_nxt;

  logic [NSRC-1:0] eligible;
  logic [7:0]      elig8, en8, pend8, ack8;
  logic [2:0]      winner;
  logic            ack_hit;
  logic            wr_en, wr_pend;
  logic [NSRC-1:0] set_v, clr_v;

  assign eligible = pending_q & enable_q;
  assign wr_en    = !RW && (AD == A_EN);
  assign wr_pend  = !RW && (AD == A_PEND);

  // Zero-extended views keep indexing and read data at a fixed 8-bit width
  // for any NSRC.
  always_comb begin
    elig8 = '0;
    en8   = '0;
    pend8 = '0;
    elig8[NSRC-1:0] = eligible;
    en8[NSRC-1:0]   = enable_q;
    pend8[NSRC-1:0] = pending_q;
  end

  // Fixed priority. The loop scans downward so that the lowest index is
  // assigned last and therefore wins.
  always_comb begin
    winner = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 3'(i);
    end
  end

  // Scheduler FSM: next state, latched vector and latched source index.
  always_comb begin
    state_nxt = state_q;
    irq2v_nxt = irq2v_q;
    idx_nxt   = idx_q;
    ack_hit   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|eligible) begin
          state_nxt = S_REQ;
          idx_nxt   = winner;
          irq2v_nxt = VOFS + {1'b0, winner};
        end
      end
      S_REQ: begin
        // The vector is frozen in REQ, so a higher-priority arrival waits
        // until this request retires.
        ack_hit = RW && (AD == {11'h7FF, irq2v_q, 1'b0});
        if (ack_hit || !elig8[idx_q]) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pending update. Level bits follow SRC directly. Edge bits use set-wins
  // semantics against acknowledge and W1C clears.
  always_comb begin
    ack8 = '0;
    ack8[idx_q] = ack_hit;
    set_v = SRC & ~src_d_q;
    clr_v = ack8[NSRC-1:0] | (wr_pend ? WDATA[NSRC-1:0] : '0);
    pending_nxt = (LVL & SRC) | (~LVL & ((pending_q & ~clr_v) | set_v));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      enable_q  <= '0;
      pending_q <= '0;
      src_d_q   <= '0;
      irq2v_q   <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_nxt;
      pending_q <= pending_nxt;
      src_d_q   <= SRC;
      irq2v_q   <= irq2v_nxt;
      idx_q     <= idx_nxt;
      if (wr_en) enable_q <= WDATA[NSRC-1:0];
    end
  end

  assign IRQ2      = (state_q == S_REQ);
  assign IRQ2V     = irq2v_q;
  assign dbg_state = (state_q == S_REQ);

  // Register read path, combinational from the bus.
  always_comb begin
    RDATA = 8'h00;
    RSEL  = 1'b0;
    if (RW) begin
      if (AD == A_EN) begin
        RDATA = en8;
        RSEL  = 1'b1;
      end else if (AD == A_PEND) begin
        RDATA = pend8;
        RSEL  = 1'b1;
      end else if (AD == A_STAT) begin
        RDATA = {IRQ2, 3'b000, irq2v_q};
        RSEL  = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hd63701_irq2_ctrl.sv
module tb_hd63701_irq2_ctrl;

  localparam logic [15:0] BASE = 16'h0040;

  logic        clk;
  logic        rst;
  logic [7:0]  src;
  logic [15:0] ad;
  logic        rw;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rsel;
  logic        irq2;
  logic [3:0]  irq2v;
  logic        dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  hd63701_irq2_ctrl #(
    .NSRC(8), .LEVEL_MASK(8'h08), .BASE(BASE), .VOFS(4'h0)
  ) dut (
    .CLK(clk), .RST(rst), .SRC(src), .AD(ad), .RW(rw), .WDATA(wdata),
    .RDATA(rdata), .RSEL(rsel), .IRQ2(irq2), .IRQ2V(irq2v),
    .dbg_state(dbg_state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks. Inputs change 1 ns after a rising edge, and outputs are
  // sampled there as well, away from the active edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    ad = a; rw = 1'b0; wdata = d;
    tick();
    ad = 16'h0000; rw = 1'b1; wdata = 8'h00;
  endtask

  // Combinational register read within the current cycle, with no edge.
  task automatic peek(input logic [15:0] a, output logic [7:0] d);
    ad = a; rw = 1'b1;
    #1;
    d = rdata;
    ad = 16'h0000;
    #1;
  endtask

  // A bus read cycle at a vector address, spanning one edge.
  task automatic vec_read(input logic [15:0] a);
    ad = a; rw = 1'b1;
    tick();
    ad = 16'h0000;
  endtask

  task automatic pulse(input int s);
    src[s] = 1'b1;
    tick();
    src[s] = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    rst = 1'b1; src = '0; ad = 16'h0000; rw = 1'b1; wdata = '0;
    tick(2);
    rst = 1'b0;
    tests_run++;
    if (irq2 !== 1'b0 || irq2v !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_irq: irq2=%b irq2v=%h expected 0/0", irq2, irq2v);
    end
    tests_run++;
    if (rsel !== 1'b0 || rdata !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_bus: rsel=%b rdata=%h expected 0/00", rsel, rdata);
    end
    peek(BASE, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_enable: got %h expected 00", d);
    end
    peek(BASE + 16'd1, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_pending: got %h expected 00", d);
    end
  endtask

  task automatic test_edge_basic;
    logic [7:0] d;
    bus_write(BASE, 8'h01);
    pulse(0);
    tests_run++;
    if (irq2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL edge_latency_early: irq2=%b expected 0", irq2);
    end
    tick();
    tests_run++;
    if (irq2 !== 1'b1 || irq2v !== 4'h0) begin
      tests_failed++;
      $display("FAIL edge_assert: irq2=%b irq2v=%h expected 1/0", irq2, irq2v);
    end
    peek(BASE + 16'd2, d);
    tests_run++;
    if (d !== 8'h80) begin
      tests_failed++;
      $display("FAIL status_req: got %h expected 80", d);
    end
    vec_read(16'hFFE0);
    tests_run++;
    if (irq2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL edge_ack: irq2=%b expected 0", irq2);
    end
    peek(BASE + 16'd1, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL edge_ack_pending: got %h expected 00", d);
    end
    tick(2);
    tests_run++;
    if (irq2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL edge_stays_low: irq2=%b expected 0", irq2);
    end
  endtask

  task automatic test_priority_freeze;
    logic [7:0] d;
    bus_write(BASE, 8'hFF);
    pulse(5);
    tick();
    tests_run++;
    if (irq2 !== 1'b1 || irq2v !== 4'h5) begin
      tests_failed++;
      $display("FAIL prio_first: irq2=%b irq2v=%h expected 1/5", irq2, irq2v);
    end
    pulse(2);
    tick();
    tests_run++;
    if (irq2 !== 1'b1 || irq2v !== 4'h5) begin
      tests_failed++;
      $display("FAIL prio_frozen: irq2=%b irq2v=%h expected 1/5", irq2, irq2v);
    end
    peek(BASE + 16'd1, d);
    tests_run++;
    if (d !== 8'h24) begin
      tests_failed++;
      $display("FAIL prio_pending: got %h expected 24", d);
    end
    // A read of another vector is not an acknowledge.
    vec_read(16'hFFE4);
    tests_run++;
    if (irq2 !== 1'b1 || irq2v !== 4'h5) begin
      tests_failed++;
      $display("FAIL wrong_vec: irq2=%b irq2v=%h expected 1/5", irq2, irq2v);
    end
    vec_read(16'hFFEA);
    tests_run++;
    if (irq2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL prio_ack: irq2=%b expected 0", irq2);
    end
    tick();
    tests_run++;
    if (irq2 !== 1'b1 || irq2v !== 4'h2) begin
      tests_failed++;
      $display("FAIL prio_rearb: irq2=%b irq2v=%h expected 1/2", irq2, irq2v);
    end
    vec_read(16'hFFE4);
    tick();
    tests_run++;
    if (irq2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL prio_drain: irq2=%b expected 0", irq2);
    end
    // A vector read while IDLE does nothing.
    vec_read(16'hFFE4);
    tests_run++;
    if (irq2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_vec_read: irq2=%b expected 0", irq2);
    end
  endtask

  task automatic test_level;
    src[3] = 1'b1;
    tick(2);
    tests_run++;
    if (irq2 !== 1'b1 || irq2v !== 4'h3) begin
      tests_failed++;
      $display("FAIL level_assert: irq2=%b irq2v=%h expected 1/3", irq2, irq2v);
    end
    vec_read(16'hFFE6);
    tests_run++;
    if (irq2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL level_ack: irq2=%b expected 0", irq2);
    end
    tick();
    tests_run++;
    if (irq2 !== 1'b1 || irq2v !== 4'h3) begin
      tests_failed++;
      $display("FAIL level_reassert: irq2=%b irq2v=%h expected 1/3", irq2, irq2v);
    end
    src[3] = 1'b0;
    tick(2);
    tests_run++;
    if (irq2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL level_drop: irq2=%b expected 0", irq2);
    end
    tick(3);
    tests_run++;
    if (irq2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL level_stays_low: irq2=%b expected 0", irq2);
    end
  endtask

  task automatic test_masked_w1c;
    logic [7:0] d;
    bus_write(BASE, 8'h00);
    pulse(1);
    tick(2);
    tests_run++;
    if (irq2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL masked_no_irq: irq2=%b expected 0", irq2);
    end
    peek(BASE + 16'd1, d);
    tests_run++;
    if (d !== 8'h02) begin
      tests_failed++;
      $display("FAIL masked_pending: got %h expected 02", d);
    end
    bus_write(BASE + 16'd1, 8'h02);
    peek(BASE + 16'd1, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL w1c_clear: got %h expected 00", d);
    end
    bus_write(BASE, 8'h02);
    tick(2);
    tests_run++;
    if (irq2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL w1c_no_irq: irq2=%b expected 0", irq2);
    end
    // Level bits ignore W1C.
    bus_write(BASE, 8'h00);
    src[3] = 1'b1;
    tick();
    bus_write(BASE + 16'd1, 8'h08);
    peek(BASE + 16'd1, d);
    tests_run++;
    if (d !== 8'h08) begin
      tests_failed++;
      $display("FAIL w1c_level_ignored: got %h expected 08", d);
    end
    src[3] = 1'b0;
    tick();
  endtask

  task automatic test_held_edge;
    bus_write(BASE, 8'h02);
    src[1] = 1'b1;
    tick(2);
    tests_run++;
    if (irq2 !== 1'b1 || irq2v !== 4'h1) begin
      tests_failed++;
      $display("FAIL held_assert: irq2=%b irq2v=%h expected 1/1", irq2, irq2v);
    end
    vec_read(16'hFFE2);
    tick(3);
    tests_run++;
    if (irq2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL held_single_set: irq2=%b expected 0", irq2);
    end
    src[1] = 1'b0;
    tick();
  endtask

  task automatic test_disable;
    logic [7:0] d;
    bus_write(BASE, 8'h01);
    pulse(0);
    tick();
    bus_write(BASE, 8'h00);
    tests_run++;
    if (irq2 !== 1'b1) begin
      tests_failed++;
      $display("FAIL disable_lag: irq2=%b expected 1", irq2);
    end
    tick();
    tests_run++;
    if (irq2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL disable_drop: irq2=%b expected 0", irq2);
    end
    peek(BASE + 16'd1, d);
    tests_run++;
    if (d !== 8'h01) begin
      tests_failed++;
      $display("FAIL disable_pending_kept: got %h expected 01", d);
    end
    bus_write(BASE + 16'd1, 8'h01);
  endtask

  task automatic test_back_to_back;
    logic [7:0] d;
    bus_write(BASE, 8'h10);
    pulse(4);
    tick();
    tests_run++;
    if (irq2 !== 1'b1 || irq2v !== 4'h4) begin
      tests_failed++;
      $display("FAIL b2b_assert: irq2=%b irq2v=%h expected 1/4", irq2, irq2v);
    end
    // A new edge lands in the same cycle as the acknowledge.
    src[4] = 1'b1;
    vec_read(16'hFFE8);
    src[4] = 1'b0;
    tests_run++;
    if (irq2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_ack: irq2=%b expected 0", irq2);
    end
    peek(BASE + 16'd1, d);
    tests_run++;
    if (d !== 8'h10) begin
      tests_failed++;
      $display("FAIL b2b_set_wins: got %h expected 10", d);
    end
    tick();
    tests_run++;
    if (irq2 !== 1'b1 || irq2v !== 4'h4) begin
      tests_failed++;
      $display("FAIL b2b_reassert: irq2=%b irq2v=%h expected 1/4", irq2, irq2v);
    end
    vec_read(16'hFFE8);
  endtask

  task automatic test_reset_mid_req;
    logic [7:0] d;
    bus_write(BASE, 8'h04);
    pulse(2);
    tick();
    tests_run++;
    if (irq2 !== 1'b1 || irq2v !== 4'h2) begin
      tests_failed++;
      $display("FAIL rst_pre: irq2=%b irq2v=%h expected 1/2", irq2, irq2v);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (irq2 !== 1'b0 || irq2v !== 4'h0) begin
      tests_failed++;
      $display("FAIL rst_mid: irq2=%b irq2v=%h expected 0/0", irq2, irq2v);
    end
    peek(BASE, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL rst_mid_enable: got %h expected 00", d);
    end
    peek(BASE + 16'd1, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL rst_mid_pending: got %h expected 00", d);
    end
    peek(BASE + 16'd2, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL rst_mid_status: got %h expected 00", d);
    end
  endtask

  initial begin
    test_reset();
    test_edge_basic();
    test_priority_freeze();
    test_level();
    test_masked_w1c();
    test_held_edge();
    test_disable();
    test_back_to_back();
    test_reset_mid_req();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hd63701_irq2_ctrl.md
# hd63701_irq2_ctrl

Prioritised interrupt scheduler that merges up to eight on-chip peripheral interrupt sources onto the HD63701 core's single IRQ2 request and 4-bit IRQ2V vector-select input. It sits beside the core on the core's CPU clock and snoops the core's address bus to detect the vector fetch that acknowledges an interrupt. It exposes enable, pending and status registers in the core's address space.

## Interface
Parameters:
- NSRC, 8: number of sources, 1..8.
- LEVEL_MASK, 8'h00: bit i = 1 makes source i level-sensitive; 0 makes it rising-edge.
- BASE, 16'h0040: register block base address; occupies BASE..BASE+2.
- VOFS, 4'h0: IRQ2V value for source 0. VOFS+NSRC ≤ 16.

Ports:
- CLK  in  1  core CPU clock (the core's CLKo); one bus cycle per CLK.
- RST  in  1  synchronous, active-high reset.
- SRC  in  NSRC  interrupt requests, synchronous to CLK.
- AD  in  16  core address bus.
- RW  in  1  core read(1)/write(0).
- WDATA  in  8  core data out (core DO).
- RDATA  out  8  register read data, combinational from AD.
- RSEL  out  1  AD hits BASE..BASE+2 with RW=1; steers the core DI mux.
- IRQ2  out  1  interrupt request to core, registered.
- IRQ2V  out  4  vector select to core, registered.

## Operation
- Edge detect: edge source i sets pending[i] when SRC[i]=1 and SRC_d[i]=0, where SRC_d is SRC registered. Level source i: pending[i] = SRC[i] (registered copy).
- Eligible = pending & enable. Fixed priority: lowest index wins.
- States: IDLE (IRQ2=0), REQ (IRQ2=1).
- IDLE→REQ when eligible≠0: IRQ2←1, IRQ2V←VOFS+winner index, latched.
- In REQ, IRQ2V is frozen even if a higher-priority source becomes eligible.
- REQ→IDLE on acknowledge: a cycle with RW=1 and AD = {11'h7FF, IRQ2V, 1'b0}, i.e. 16'hFFE0 + 2·IRQ2V.
  - On acknowledge, an edge source's pending bit clears.
  - A level source is not cleared; it must drop SRC.
- REQ→IDLE without acknowledge when the latched source is no longer eligible (disabled, W1C-cleared, or level dropped).
- Registers:
  - BASE+0 ENABLE: R/W, bits NSRC-1:0; unused bits read 0.
  - BASE+1 PENDING: read returns pending. Write-1-to-clear on edge-source bits only; writes to level-source bits are ignored.
  - BASE+2 STATUS: read {IRQ2, 3'b0, IRQ2V}; writes ignored.
- Writes occur when RW=0 and AD matches; WDATA is sampled on that CLK edge.

## Timing
- Reset values: ENABLE=0, pending=0, SRC_d=0, state IDLE, IRQ2=0, IRQ2V=0. RDATA=0 and RSEL=0 unless AD/RW select a register.
- Reset has priority over every other event, including mid-REQ: IRQ2 drops on the next edge.
- Latency, edge source: SRC rises in cycle n → pending set at edge n+1 → IRQ2=1 at edge n+2.
- Latency, level source: SRC=1 in cycle n → pending set at edge n+1 → IRQ2=1 at edge n+2.
- Acknowledge in cycle a → at edge a+1: IRQ2=0 and pending bit cleared. Earliest re-assertion of IRQ2 is edge a+2, with re-arbitrated IRQ2V.
- Simultaneous set and clear of the same pending bit (new edge plus acknowledge or W1C): set wins, bit stays 1.
- ENABLE write takes effect on eligibility at the next edge. Disabling the latched source in REQ drops IRQ2 one edge later.
- A read of the vector address while IDLE, or with a non-matching IRQ2V, is not an acknowledge.
- Source held high on an edge input: one pending set only; a new request needs a 0→1 transition.
- IRQ2 and IRQ2V change only on CLK edges. IRQ2V never changes while IRQ2=1.

## Test plan
- Reset, then ENABLE=8'h01 and a 1-cycle pulse on SRC[0] → IRQ2=1, IRQ2V=0 two edges later. Read FFE0 → IRQ2=0 next edge; PENDING reads 8'h00.
- ENABLE=8'hFF, pulse SRC[5] and then SRC[2] one cycle later while in REQ → IRQ2V stays 5. After read of FFEA, IRQ2 drops, then re-asserts with IRQ2V=2 one edge later.
- LEVEL_MASK=8'h08, SRC[3] held high, read FFE6 → IRQ2 drops for one cycle and re-asserts with IRQ2V=3. Drop SRC[3] → IRQ2=0 within 2 edges and stays 0.
- Pulse SRC[1] with ENABLE=0 → no IRQ2; PENDING reads 8'h02. Write 8'h02 to BASE+1 → PENDING=0. Enable bit 1 → still no IRQ2.
- In REQ on source 4, assert a new SRC[4] edge in the same cycle as the FFE8 acknowledge read → pending[4] stays 1 and IRQ2 re-asserts with IRQ2V=4.
- Assert RST while IRQ2=1 → next edge: IRQ2=0, IRQ2V=0, ENABLE=0, PENDING=0. STATUS reads 8'h00.
